// File: rtl/riscv_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_fetch_ctrl
//   Instruction-fetch sequencer. Owns the PC, runs a single-outstanding
//   request/ack port towards instruction memory, and loads the IF/ID
//   register. A taken PC+imm redirect from the ID-stage branch decoder moves
//   the PC to the target, flushes the wrong-path instruction, and throws away
//   the data of any request still in flight. A misaligned target is sent to
//   TRAP_VEC instead.
//
// Ports
//   Clk_i, Rst_i        clock, synchronous active-high reset
//   Stall_i             ID cannot take a new instruction this cycle
//   Branch_en_i         taken jump/branch sitting in ID
//   PC_mux_sel_i        00 PC+4, 01 PC+imm, 1x reserved (acts as 00)
//   Bra_pc_i, Imm_i     PC and sign-extended immediate of the ID instruction
//   Imem_req_o          fetch request (held until Imem_ack_i)
//   Imem_addr_o         fetch address (held until Imem_ack_i)
//   Imem_ack_i          Imem_rdata_i is valid this cycle
//   Imem_rdata_i        fetched instruction word
//   Inst_o, Inst_pc_o   instruction and its PC towards IF/ID
//   Inst_valid_o        Inst_o / Inst_pc_o are valid
//   Flush_o             one-cycle pulse: kill the instruction in ID
//   Misalign_o          one-cycle pulse: redirect target was misaligned
// -----------------------------------------------------------------------------
module riscv_fetch_ctrl #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = '0,
  parameter logic [AW-1:0]   TRAP_VEC = AW'('h100)
) (
  input  logic          Clk_i,
  input  logic          Rst_i,
  input  logic          Stall_i,
  input  logic          Branch_en_i,
  input  logic [1:0]    PC_mux_sel_i,
  input  logic [AW-1:0] Bra_pc_i,
  input  logic [AW-1:0] Imm_i,
  output logic          Imem_req_o,
  output logic [AW-1:0] Imem_addr_o,
  input  logic          Imem_ack_i,
  input  logic [31:0]   Imem_rdata_i,
  output logic [31:0]   Inst_o,
  output logic [AW-1:0] Inst_pc_o,
  output logic          Inst_valid_o,
  output logic          Flush_o,
  output logic          Misalign_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    BOOT,   // one idle cycle after reset, no request
    FETCH,  // request at pc outstanding
    HOLD,   // instruction captured while ID stalled, no request
    DRAIN   // stale request outstanding, its data will be discarded
  } state_t;

  state_t        state;
  logic [AW-1:0] pc;

  logic          redirect;
  logic [AW-1:0] target;
  logic          target_misaligned;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] pc_plus4;

  // A branch held in ID by a stall stays there, so the redirect simply waits
  // until the stall clears.
  assign redirect          = Branch_en_i && (PC_mux_sel_i == 2'b01) && !Stall_i;
  assign target            = Bra_pc_i + Imm_i;
  assign target_misaligned = (target[1:0] != 2'b00);
  assign redirect_pc       = target_misaligned ? TRAP_VEC : target;
  assign pc_plus4          = pc + AW'(4);

  // NOTE: every register here is updated with non-blocking assignments so
  // that all decisions in one cycle see the pre-edge values of pc/state.
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      // NOTE: reset is synchronous, so it lives inside the clocked branch and
      // any request in flight is simply forgotten (BOOT ignores a late ack).
      state        <= BOOT;
      pc           <= RESET_PC;
      Imem_req_o   <= 1'b0;
      Imem_addr_o  <= RESET_PC;
      Inst_o       <= NOP;
      Inst_pc_o    <= '0;
      Inst_valid_o <= 1'b0;
      Flush_o      <= 1'b0;
      Misalign_o   <= 1'b0;
    end else begin
      Flush_o    <= 1'b0;
      Misalign_o <= 1'b0;

      if (redirect) begin
        Flush_o      <= 1'b1;
        Misalign_o   <= target_misaligned;
        Inst_valid_o <= 1'b0;
        pc           <= redirect_pc;
        Imem_req_o   <= 1'b1;
        // A request still waiting for its ack must complete on the bus with
        // its original address; its data is then dropped in DRAIN.
        if ((state == FETCH || state == DRAIN) && !Imem_ack_i) begin
          state <= DRAIN;
        end else begin
          state       <= FETCH;
          Imem_addr_o <= redirect_pc;
        end
      end else begin
        unique case (state)
          BOOT: begin
            state       <= FETCH;
            Imem_req_o  <= 1'b1;
            Imem_addr_o <= pc;
          end

          FETCH: begin
            if (Imem_ack_i) begin
              Inst_o       <= Imem_rdata_i;
              Inst_pc_o    <= pc;
              Inst_valid_o <= 1'b1;
              pc           <= pc_plus4;
              Imem_addr_o  <= pc_plus4;
              if (Stall_i) begin
                state      <= HOLD;
                Imem_req_o <= 1'b0;
              end
            end else if (!Stall_i) begin
              Inst_valid_o <= 1'b0;  // bubble while waiting for memory
            end
          end

          HOLD: begin
            if (!Stall_i) begin
              state        <= FETCH;
              Imem_req_o   <= 1'b1;
              Imem_addr_o  <= pc;
              Inst_valid_o <= 1'b0;
            end
          end

          DRAIN: begin
            if (Imem_ack_i) begin
              state       <= FETCH;
              Imem_addr_o <= pc;
            end
          end

          default: state <= BOOT;
        endcase
      end
    end
  end

endmodule
